finder_row_scanner: RTL and testbench

Streaming detector for QR finder-pattern candidates along image rows. It sits downstream of the binarizer, in parallel with the 1-bit frame buffer write. It consumes the recovered camera pixel stream in raster order: one binarized bit plus hcount and vcount per valid cycle. For every dark:light:dark:light:dark run sequence within the 1:1:3:1:1 tolerance window, it emits the sequence's centre coordinate and total width, and it keeps a per-frame hit count.

---
 rtl/finder_row_scanner.sv | 248 ++++++++++++++++++++++++
 tb/tb_finder_row_scanner.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/finder_row_scanner.sv
// finder_row_scanner: streaming detector for QR finder-pattern candidates.
// Tracks dark/light run lengths along each binarized row and tests the last
// five closed runs (dark, light, dark, light, dark) against the 1:1:3:1:1
// ratio window. Accepted candidates are reported as centre column, row and
// total width three cycles after the pixel that closes the final dark run.
// A saturating per-frame hit count is published on each end-of-frame pulse.
module finder_row_scanner #(
  parameter int WIDTH     = 480,
  parameter int MIN_WIDTH = 7
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  logic        bin_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        frame_done_in,
  output logic        hit_valid_out,
  output logic [10:0] hit_hcount_out,
  output logic [9:0]  hit_vcount_out,
  output logic [11:0] hit_width_out,
  output logic [7:0]  hit_count_out
);

  localparam logic [10:0] LAST_H   = 11'(WIDTH - 1);
  localparam logic [10:0] RUN_MAX  = 11'd2047;
  localparam logic [2:0]  HIST_MAX = 3'd5;
  localparam logic [11:0] MIN_T    = 12'(MIN_WIDTH);
  localparam logic [7:0]  HITS_MAX = 8'd255;

  // Run history: index 4 is the oldest run (r1), index 0 the newest (r5).
  typedef logic [4:0][10:0] hist_t;

  // Shift a freshly closed run into the newest slot; the oldest drops out.
  function automatic hist_t push_run(input logic [3:0][10:0] keep, input logic [10:0] len);
    return {keep, len};
  endfunction

  function automatic logic [2:0] count_inc(input logic [2:0] c);
    return (c >= HIST_MAX) ? HIST_MAX : c + 3'd1;
  endfunction

  // ---------------------------------------------------------------- stage 0
  logic        r_color;      // colour of the run in progress (1 = light)
  logic [10:0] r_run;        // length of the run in progress
  hist_t       r_hist;
  logic [2:0]  r_closed;     // closed runs this row, saturating at 5
  logic [10:0] r_prev_h;     // hcount of the previous valid pixel

  logic        w_color_nxt;
  logic [10:0] w_run_nxt;
  hist_t       w_hist_nxt;
  logic [2:0]  w_closed_nxt;
  logic        w_eval;
  hist_t       w_eval_hist;
  logic [10:0] w_eval_end_h;

  logic [10:0] w_run_inc;
  hist_t       w_hist_push;
  logic [2:0]  w_closed_push;

  assign w_run_inc     = (r_run == RUN_MAX) ? RUN_MAX : r_run + 11'd1;
  assign w_hist_push   = push_run(r_hist[3:0], r_run);
  assign w_closed_push = count_inc(r_closed);

  // Next run state and evaluation request for the current pixel.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_color_nxt  = r_color;
    w_run_nxt    = r_run;
    w_hist_nxt   = r_hist;
    w_closed_nxt = r_closed;
    w_eval       = 1'b0;
    w_eval_hist  = w_hist_push;
    w_eval_end_h = r_prev_h;
    if (valid_in) begin
      if (hcount_in == 11'd0) begin
        // Row start discards anything left over, including a row whose last pixel was lost.
        w_hist_nxt   = '0;
        w_closed_nxt = '0;
        w_color_nxt  = bin_in;
        w_run_nxt    = 11'd1;
      end else if (hcount_in == LAST_H) begin
        if (bin_in == r_color) begin
          // Last pixel extends the current run, which then closes here.
          w_eval       = !r_color && (w_closed_push == HIST_MAX);
          w_eval_hist  = push_run(r_hist[3:0], w_run_inc);
          w_eval_end_h = hcount_in;
        end else if (!r_color) begin
          // A dark run closes at the previous pixel; the trailing light pixel cannot complete a pattern.
          w_eval       = (w_closed_push == HIST_MAX);
          w_eval_hist  = w_hist_push;
          w_eval_end_h = r_prev_h;
        end else begin
          // Light run closes, then the single dark last pixel closes as its own run.
          w_eval       = (count_inc(w_closed_push) == HIST_MAX);
          w_eval_hist  = push_run(w_hist_push[3:0], 11'd1);
          w_eval_end_h = hcount_in;
        end
        w_hist_nxt   = '0;
        w_closed_nxt = '0;
        w_color_nxt  = 1'b1;
        w_run_nxt    = '0;
      end else if (bin_in == r_color) begin
        w_run_nxt = w_run_inc;
      end else begin
        w_hist_nxt   = w_hist_push;
        w_closed_nxt = w_closed_push;
        w_eval       = !r_color && (w_closed_push == HIST_MAX);
        w_eval_hist  = w_hist_push;
        w_eval_end_h = r_prev_h;
        w_color_nxt  = bin_in;
        w_run_nxt    = 11'd1;
      end
    end
  end

  // Run tracker registers; they move only on valid pixels.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_color  <= 1'b1;
      r_run    <= '0;
      r_hist   <= '0;
      r_closed <= '0;
      r_prev_h <= '0;
    end else if (valid_in) begin
      r_color  <= w_color_nxt;
      r_run    <= w_run_nxt;
      r_hist   <= w_hist_nxt;
      r_closed <= w_closed_nxt;
      r_prev_h <= hcount_in;
    end
  end

  // ---------------------------------------------------------------- stage 1/2 datapath
  logic        r_s0_valid;
  hist_t       r_s0_hist;
  logic [10:0] r_s0_end_h;
  logic [9:0]  r_s0_v;

  logic        r_s1_valid;
  logic [11:0] r_s1_t;
  logic [4:0][15:0] r_s1_r14;
  logic [15:0] r_s1_t3;
  logic [15:0] r_s1_t5;
  logic [15:0] r_s1_t7;
  logic [10:0] r_s1_end_h;
  logic [9:0]  r_s1_v;

  logic [11:0] w_t;
  logic [15:0] w_t16;
  logic [4:0][15:0] w_r14;
  logic [15:0] w_s1_t16;
  logic        w_ratio_ok;
  logic        w_accept;

  assign w_t = {1'b0, r_s0_hist[0]} + {1'b0, r_s0_hist[1]} + {1'b0, r_s0_hist[2]}
             + {1'b0, r_s0_hist[3]} + {1'b0, r_s0_hist[4]};
  assign w_t16 = {4'b0, w_t};

  // 14*r as (r << 4) - (r << 1) for each of the five runs.
  always_comb begin
    w_r14 = '0;
    for (int i = 0; i < 5; i++) begin
      w_r14[i] = ({5'b0, r_s0_hist[i]} << 4) - ({5'b0, r_s0_hist[i]} << 1);
    end
  end

  // Pipeline valid bits; reset drops any evaluation in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s0_valid <= 1'b0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s0_valid <= w_eval;
      r_s1_valid <= r_s0_valid;
    end
  end

  // Pipeline payload: capture the candidate, then form T and its scaled bounds.
  // NOTE: payload registers are left unreset; nothing reads them unless the matching valid bit is set.
  always_ff @(posedge clk_in) begin
    if (w_eval) begin
      r_s0_hist  <= w_eval_hist;
      r_s0_end_h <= w_eval_end_h;
      r_s0_v     <= vcount_in;
    end
    r_s1_t     <= w_t;
    r_s1_r14   <= w_r14;
    r_s1_t3    <= (w_t16 << 1) + w_t16;
    r_s1_t5    <= (w_t16 << 2) + w_t16;
    r_s1_t7    <= (w_t16 << 3) - w_t16;
    r_s1_end_h <= r_s0_end_h;
    r_s1_v     <= r_s0_v;
  end

  assign w_s1_t16 = {4'b0, r_s1_t};

  // Ratio window: outer runs 14r in [T, 3T], centre run 14r in [5T, 7T].
  always_comb begin
    w_ratio_ok = (r_s1_r14[2] >= r_s1_t5) && (r_s1_r14[2] <= r_s1_t7);
    for (int i = 0; i < 5; i++) begin
      if (i != 2) begin
        w_ratio_ok = w_ratio_ok && (r_s1_r14[i] >= w_s1_t16) && (r_s1_r14[i] <= r_s1_t3);
      end
    end
  end

  assign w_accept = r_s1_valid && w_ratio_ok && (r_s1_t >= MIN_T);

  // Hit outputs: strobe for one cycle, coordinates hold until the next hit.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_valid_out  <= 1'b0;
      hit_hcount_out <= '0;
      hit_vcount_out <= '0;
      hit_width_out  <= '0;
    end else begin
      hit_valid_out <= w_accept;
      if (w_accept) begin
        hit_hcount_out <= r_s1_end_h - 11'(r_s1_t >> 1);
        hit_vcount_out <= r_s1_v;
        hit_width_out  <= r_s1_t;
      end
    end
  end

  // ---------------------------------------------------------------- frame counter
  logic [7:0] r_hit_cnt;
  logic [7:0] w_hit_cnt_inc;

  assign w_hit_cnt_inc = (r_hit_cnt == HITS_MAX) ? HITS_MAX : r_hit_cnt + 8'd1;

  // Count strobed hits; on end of frame publish the count (including a coincident hit) and restart.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_hit_cnt     <= '0;
      hit_count_out <= '0;
    end else if (frame_done_in) begin
      hit_count_out <= hit_valid_out ? w_hit_cnt_inc : r_hit_cnt;
      r_hit_cnt     <= '0;
    end else if (hit_valid_out) begin
      r_hit_cnt <= w_hit_cnt_inc;
    end
  end

endmodule

// File: tb/tb_finder_row_scanner.sv
// tb_finder_row_scanner: directed stimulus for finder_row_scanner with a
// behavioural run-length model that pushes expected hits into a scoreboard;
// a negedge monitor pops and compares them as the DUT strobes.
module tb_finder_row_scanner;

  localparam int WIDTH     = 480;
  localparam int MIN_WIDTH = 7;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic        bin_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        frame_done_in;
  logic        hit_valid_out;
  logic [10:0] hit_hcount_out;
  logic [9:0]  hit_vcount_out;
  logic [11:0] hit_width_out;
  logic [7:0]  hit_count_out;

  finder_row_scanner #(.WIDTH(WIDTH), .MIN_WIDTH(MIN_WIDTH)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .valid_in       (valid_in),
    .bin_in         (bin_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .frame_done_in  (frame_done_in),
    .hit_valid_out  (hit_valid_out),
    .hit_hcount_out (hit_hcount_out),
    .hit_vcount_out (hit_vcount_out),
    .hit_width_out  (hit_width_out),
    .hit_count_out  (hit_count_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int h;
    int v;
    int w;
    int due;
  } exp_t;

  exp_t sb[$];
  int   exp_pushed = 0;
  int   n_hits = 0;
  int   last_h = 0;
  int   last_v = 0;
  int   last_w = 0;

  int   cur_h = 0;
  int   cur_v = 0;
  bit   gap = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------ reference model
  bit m_color;
  int m_run;
  int m_hist[$];
  int m_cnt;
  int m_prev_h;

  task automatic model_reset();
    m_color  = 1'b1;
    m_run    = 0;
    m_hist.delete();
    m_cnt    = 0;
    m_prev_h = 0;
  endtask

  task automatic model_close(input bit col, input int len, input int end_h, input int v);
    int   t;
    bit   ok;
    exp_t e;
    m_hist.push_back(len);
    if (m_hist.size() > 5) void'(m_hist.pop_front());
    if (m_cnt < 5) m_cnt++;
    if (col == 1'b0 && m_cnt >= 5) begin
      t  = (m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3] + m_hist[4]) % 4096;
      ok = (t >= MIN_WIDTH);
      for (int i = 0; i < 5; i++) begin
        if (i == 2) ok = ok && (14 * m_hist[i] >= 5 * t) && (14 * m_hist[i] <= 7 * t);
        else        ok = ok && (14 * m_hist[i] >= t)     && (14 * m_hist[i] <= 3 * t);
      end
      if (ok) begin
        e.h   = (end_h - t / 2) & 2047;
        e.v   = v;
        e.w   = t;
        e.due = cyc + 3;
        sb.push_back(e);
        exp_pushed++;
      end
    end
  endtask

  task automatic model_step(input bit b, input int h, input int v);
    if (h == 0) begin
      m_hist.delete();
      m_cnt   = 0;
      m_color = b;
      m_run   = 1;
    end else if (h == WIDTH - 1) begin
      if (b == m_color) begin
        m_run = (m_run < 2047) ? m_run + 1 : 2047;
        model_close(m_color, m_run, h, v);
      end else begin
        model_close(m_color, m_run, m_prev_h, v);
        model_close(b, 1, h, v);
      end
      m_hist.delete();
      m_cnt   = 0;
      m_color = 1'b1;
      m_run   = 0;
    end else if (b == m_color) begin
      m_run = (m_run < 2047) ? m_run + 1 : 2047;
    end else begin
      model_close(m_color, m_run, m_prev_h, v);
      m_color = b;
      m_run   = 1;
    end
    m_prev_h = h;
  endtask

  // ------------------------------------------------------------ monitor
  exp_t mon_e;
  always @(negedge clk_in) begin
    if (rst_in !== 1'b1) begin
      if (hit_valid_out === 1'b1) begin
        n_hits++;
        last_h = int'(hit_hcount_out);
        last_v = int'(hit_vcount_out);
        last_w = int'(hit_width_out);
        check("hit_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("hit_hcount", hit_hcount_out, mon_e.h);
          check("hit_vcount", hit_vcount_out, mon_e.v);
          check("hit_width", hit_width_out, mon_e.w);
          check("hit_latency_cycle", cyc, mon_e.due);
        end
      end
      while (sb.size() > 0 && sb[0].due < cyc) begin
        mon_e = sb.pop_front();
        check("hit_missing_cycle", cyc, mon_e.due);
      end
    end
  end

  // ------------------------------------------------------------ stimulus helpers
  task automatic drive_pix(input bit b);
    @(negedge clk_in);
    valid_in      = 1'b1;
    bin_in        = b;
    hcount_in     = 11'(cur_h);
    vcount_in     = 10'(cur_v);
    frame_done_in = 1'b0;
    model_step(b, cur_h, cur_v);
    cur_h++;
    if (gap) begin
      @(negedge clk_in);
      valid_in = 1'b0;
    end
  endtask

  task automatic run_px(input bit b, input int n);
    repeat (n) drive_pix(b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_in);
      valid_in      = 1'b0;
      frame_done_in = 1'b0;
    end
  endtask

  task automatic start_row(input int v);
    cur_h = 0;
    cur_v = v;
  endtask

  task automatic pad_row();
    while (cur_h < WIDTH) drive_pix(1'b1);
  endtask

  // Clean unit-4 pattern up to and including the fourth run (light 30..33).
  task automatic clean_upto_r4(input int v);
    start_row(v);
    run_px(1'b1, 10);
    run_px(1'b0, 4);
    run_px(1'b1, 4);
    run_px(1'b0, 12);
    run_px(1'b1, 4);
  endtask

  task automatic pulse_frame_done();
    @(negedge clk_in);
    valid_in      = 1'b0;
    frame_done_in = 1'b1;
    @(negedge clk_in);
    frame_done_in = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk_in);
    rst_in        = 1'b1;
    valid_in      = 1'b0;
    frame_done_in = 1'b0;
    model_reset();
    sb.delete();
    repeat (n) @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, hit_valid_out, 0);
    check({tag, "_hcount"}, hit_hcount_out, 0);
    check({tag, "_vcount"}, hit_vcount_out, 0);
    check({tag, "_width"}, hit_width_out, 0);
    check({tag, "_count"}, hit_count_out, 0);
  endtask

  // ------------------------------------------------------------ watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------------ directed sequence
  int base;
  int hits_before;
  initial begin
    rst_in        = 1'b1;
    valid_in      = 1'b0;
    bin_in        = 1'b1;
    hcount_in     = '0;
    vcount_in     = '0;
    frame_done_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_in);
    check_all_zero("reset");
    rst_in = 1'b0;

    // Clean pattern, unit 4, row 100.
    clean_upto_r4(100);
    run_px(1'b0, 4);
    pad_row();
    idle(5);
    check("clean_hits", n_hits, 1);
    check("clean_hcount", last_h, 23);
    check("clean_vcount", last_v, 100);
    check("clean_width", last_w, 28);

    // Bad centre: runs 4,4,6,4,4.
    start_row(101);
    run_px(1'b1, 10);
    run_px(1'b0, 4);
    run_px(1'b1, 4);
    run_px(1'b0, 6);
    run_px(1'b1, 4);
    run_px(1'b0, 4);
    pad_row();
    idle(5);
    check("bad_centre_hits", n_hits, 1);
    check("hold_hcount", hit_hcount_out, 23);

    // Minimum-size pattern ending on the last column of row 5.
    start_row(5);
    while (cur_h < WIDTH - 7) drive_pix(1'b1);
    run_px(1'b0, 1);
    run_px(1'b1, 1);
    run_px(1'b0, 3);
    run_px(1'b1, 1);
    run_px(1'b0, 1);
    idle(5);
    check("min_hits", n_hits, 2);
    check("min_hcount", last_h, WIDTH - 4);
    check("min_vcount", last_v, 5);
    check("min_width", last_w, 7);

    // Pattern split across rows 7 and 8.
    start_row(7);
    while (cur_h < WIDTH - 5) drive_pix(1'b1);
    run_px(1'b0, 1);
    run_px(1'b1, 1);
    run_px(1'b0, 3);
    start_row(8);
    run_px(1'b1, 1);
    run_px(1'b0, 1);
    pad_row();
    idle(5);
    check("split_hits", n_hits, 2);

    // Clean pattern with valid_in low on alternate cycles.
    gap = 1'b1;
    clean_upto_r4(100);
    run_px(1'b0, 4);
    pad_row();
    gap = 1'b0;
    idle(5);
    check("gapped_hits", n_hits, 3);
    check("gapped_hcount", last_h, 23);
    check("gapped_vcount", last_v, 100);
    check("gapped_width", last_w, 28);

    // Three hits so far in this frame.
    pulse_frame_done();
    check("frame_count_3", hit_count_out, 3);

    // 300 hits in one frame saturate at 255.
    base        = exp_pushed;
    hits_before = n_hits;
    cur_v       = 200;
    while (exp_pushed - base < 300) begin
      start_row(cur_v);
      run_px(1'b1, 1);
      while (cur_h + 8 <= WIDTH - 2 && exp_pushed - base < 300) begin
        run_px(1'b0, 1);
        run_px(1'b1, 1);
        run_px(1'b0, 3);
        run_px(1'b1, 1);
        run_px(1'b0, 1);
        run_px(1'b1, 1);
      end
      pad_row();
      cur_v = cur_v + 1;
    end
    idle(5);
    check("sat_hits_seen", n_hits - hits_before, 300);
    pulse_frame_done();
    check("frame_count_sat", hit_count_out, 255);

    // Hit strobe coinciding with frame_done_in belongs to the closing frame.
    clean_upto_r4(120);
    run_px(1'b0, 4);
    drive_pix(1'b1);
    idle(2);
    @(negedge clk_in);
    valid_in      = 1'b0;
    frame_done_in = 1'b1;
    check("coincide_strobe", hit_valid_out, 1);
    @(negedge clk_in);
    frame_done_in = 1'b0;
    check("coincide_count", hit_count_out, 1);
    pulse_frame_done();
    check("next_frame_count", hit_count_out, 0);

    // Reset with an evaluation in flight: no strobe may follow.
    clean_upto_r4(100);
    run_px(1'b0, 4);
    drive_pix(1'b1);
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      check("inflight_no_strobe", hit_valid_out, 0);
    end
    check_all_zero("after_reset");

    // Reset after r1..r4, then continue with r5 and light.
    clean_upto_r4(100);
    do_reset(2);
    run_px(1'b0, 4);
    pad_row();
    idle(5);
    check_all_zero("midrow");

    // Fresh full pattern after reset.
    hits_before = n_hits;
    clean_upto_r4(101);
    run_px(1'b0, 4);
    pad_row();
    idle(5);
    check("fresh_hits", n_hits - hits_before, 1);
    check("fresh_hcount", hit_hcount_out, 23);
    check("fresh_vcount", hit_vcount_out, 101);
    check("fresh_width", hit_width_out, 28);

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
